// File: rtl/boot_copier_pkg.sv
// Shared definitions for the boot copier: sequencer state encoding and
// the reset values of the RAM-side write port.
package boot_copier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_FINISH
  } copy_state_e;

  localparam logic [15:0] DST_BASE_DFLT   = 16'hF800;
  localparam logic [15:0] RAM_ADDR_RST_OFS = 16'h0000;
  localparam logic [7:0]  RAM_WDATA_RST   = 8'h00;

  // RAM destination for a given ROM offset; wraps modulo 2^16.
  function automatic logic [15:0] ram_addr_at(input logic [15:0] base,
                                              input logic [15:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/boot_copier.sv
// Copies the whole boot ROM into RAM at DST_BASE after reset (or on start),
// holding the CPU in reset until the last byte has been accepted.
//
// state  | meaning
// IDLE   | copy finished, waiting for start (auto-leaves after reset)
// ADDR   | present rom_addr = idx
// DATA   | ROM data valid: latch byte, RAM address, accumulate checksum
// WRITE  | ram_we held until ram_ready accepts the byte
// FINISH | one cycle: set done, release busy/cpu_hold
module boot_copier
  import boot_copier_pkg::*;
#(
  parameter int unsigned ROM_ADDR_W = 11,
  parameter logic [15:0] DST_BASE   = DST_BASE_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [15:0]           ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic                  ram_ready,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            checksum
);

  localparam logic [ROM_ADDR_W-1:0] IDX_LAST = '1;
  localparam logic [15:0] RAM_ADDR_RST = ram_addr_at(DST_BASE, RAM_ADDR_RST_OFS);

  copy_state_e           state, state_nxt;
  logic [ROM_ADDR_W-1:0] idx;
  logic [15:0]           ram_addr_q;
  logic [7:0]            ram_wdata_q;
  logic [7:0]            checksum_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // busy_q is only high in IDLE straight after reset, which makes the copy
  // start by itself on the first cycle after rst is released.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start || busy_q) state_nxt = ST_ADDR;
      ST_ADDR:   state_nxt = ST_DATA;
      ST_DATA:   state_nxt = ST_WRITE;
      ST_WRITE:  if (ram_ready) state_nxt = (idx == IDX_LAST) ? ST_FINISH : ST_ADDR;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      ram_addr_q  <= RAM_ADDR_RST;
      ram_wdata_q <= RAM_WDATA_RST;
      checksum_q  <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start || busy_q) begin
            idx        <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ST_DATA: begin
          ram_wdata_q <= rom_data;
          ram_addr_q  <= ram_addr_at(DST_BASE, 16'(idx));
          checksum_q  <= checksum_q + rom_data;
        end
        ST_WRITE: begin
          if (ram_ready && (idx != IDX_LAST)) idx <= idx + 1'b1;
        end
        ST_FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // rst forces the outputs directly so a write pending in WRITE is never
  // accepted in the reset cycle itself.
  assign rom_addr  = rst ? '0 : idx;
  assign ram_addr  = rst ? RAM_ADDR_RST : ram_addr_q;
  assign ram_wdata = rst ? RAM_WDATA_RST : ram_wdata_q;
  assign ram_we    = (state == ST_WRITE) && !rst;
  assign busy      = busy_q || rst;
  assign cpu_hold  = busy_q || rst;
  assign done      = done_q && !rst;
  assign checksum  = rst ? 8'h00 : checksum_q;

endmodule

// File: tb/tb_boot_copier.sv
// Self-checking bench for boot_copier: a full-size copier and a 16-byte
// copier that wraps the RAM address, each fed by a small boot ROM model.
module tb_boot_copier;
  import boot_copier_pkg::*;

  typedef struct packed {
    logic rst;
    logic start;
    logic ready;
  } vin_t;

  typedef struct packed {
    logic        we;
    logic [10:0] ra;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  cs;
    logic        busy;
    logic        hold;
    logic        done;
  } vout_t;

  typedef struct {
    vin_t  i;
    vout_t o;
  } vec_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst, start, ram_ready;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we, cpu_hold, busy, done;
  logic [7:0]  checksum;

  logic        rst_s, start_s, ram_ready_s;
  logic [3:0]  rom_addr_s;
  logic [7:0]  rom_data_s;
  logic [15:0] ram_addr_s;
  logic [7:0]  ram_wdata_s;
  logic        ram_we_s, cpu_hold_s, busy_s, done_s;
  logic [7:0]  checksum_s;

  int  tests = 0;
  int  fails = 0;
  int  done_rises = 0;
  int  n_wr_s = 0;
  bit  done_prev = 1'b0;
  wr_t exp_q[$];
  wr_t exp_s[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  boot_copier u_dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ready(ram_ready),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum)
  );

  boot_copier #(.ROM_ADDR_W(4), .DST_BASE(16'hFFF8)) u_dut_s (
    .clk(clk), .rst(rst_s), .start(start_s),
    .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .ram_addr(ram_addr_s), .ram_wdata(ram_wdata_s), .ram_we(ram_we_s), .ram_ready(ram_ready_s),
    .cpu_hold(cpu_hold_s), .busy(busy_s), .done(done_s), .checksum(checksum_s)
  );

  // Boot ROM models: one-cycle read latency.
  always @(posedge clk) begin
    rom_data   <= rom_addr[7:0];
    rom_data_s <= 8'(int'(rom_addr_s) * 7 + 3);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic begin_copy();
    exp_q.delete();
    for (int k = 0; k < 2048; k++) exp_q.push_back({16'(32'hF800 + k), 8'(k)});
  endtask

  task automatic begin_copy_s();
    exp_s.delete();
    for (int k = 0; k < 16; k++) exp_s.push_back({16'(32'hFFF8 + k), 8'(k * 7 + 3)});
  endtask

  task automatic wait_write(input logic [15:0] a, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ram_we && ram_addr == a) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic rdy,
                              input logic we, input logic [10:0] ra, input logic [15:0] addr,
                              input logic [7:0] wd, input logic [7:0] cs, input logic done_e);
    vec_t v;
    v.i = '{rst: r, start: s, ready: rdy};
    v.o = '{we: we, ra: ra, addr: addr, wd: wd, cs: cs, busy: 1'b1, hold: 1'b1, done: done_e};
    return v;
  endfunction

  // Scoreboards: sample just before the accepting edge, pop on each write.
  always @(negedge clk) begin
    #3;
    if (ram_we && ram_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr_extra: got write %h<=%h, expected none", ram_addr, ram_wdata);
      end else begin
        chk("wr", {ram_addr, ram_wdata}, exp_q.pop_front());
      end
    end
    if (ram_we_s && ram_ready_s) begin
      n_wr_s++;
      if (exp_s.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr_s_extra: got write %h<=%h, expected none", ram_addr_s, ram_wdata_s);
      end else begin
        chk("wr_s", {ram_addr_s, ram_wdata_s}, exp_s.pop_front());
      end
    end
    if (done && !done_prev) done_rises++;
    done_prev = done;
  end

  initial begin
    vout_t       act;
    int          n;
    int          hold;
    bit          found;
    bit          seen;
    logic [15:0] first_addr;
    logic [7:0]  first_data;

    rst = 1'b1; start = 1'b0; ram_ready = 1'b1;
    rst_s = 1'b1; start_s = 1'b0; ram_ready_s = 1'b1;

    //             rst   start ready  we    ra     addr      wd     cs     done
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 16'hF800, 8'h00, 8'h00, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 16'hF800, 8'h00, 8'h00, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 16'hF800, 8'h00, 8'h00, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 16'hF800, 8'h00, 8'h00, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 16'hF800, 8'h00, 8'h00, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 11'd1, 16'hF800, 8'h00, 8'h00, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 11'd1, 16'hF800, 8'h00, 8'h00, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd1, 16'hF801, 8'h01, 8'h01, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 11'd1, 16'hF801, 8'h01, 8'h01, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 11'd2, 16'hF801, 8'h01, 8'h01, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 11'd2, 16'hF801, 8'h01, 8'h01, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b1, 11'd2, 16'hF802, 8'h02, 8'h03, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 11'd3, 16'hF802, 8'h02, 8'h03, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 11'd3, 16'hF802, 8'h02, 8'h03, 1'b0);

    // Copy 1: power-on copy, early cycles from the table.
    begin_copy();
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].i.rst; start = vecs[i].i.start; ram_ready = vecs[i].i.ready;
      @(negedge clk);
      act = '{we: ram_we, ra: rom_addr, addr: ram_addr, wd: ram_wdata, cs: checksum,
              busy: busy, hold: cpu_hold, done: done};
      chk($sformatf("vec%0d", i), 64'(act), 64'(vecs[i].o));
    end

    // Stall the idx-3 write for 5 cycles.
    start = 1'b0; ram_ready = 1'b0; hold = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 16'hF803 && ram_wdata == 8'h03) hold++;
      if (i == 6) ram_ready = 1'b1;
    end
    chk("stall_hold_cycles", hold, 6);

    // start coincident with FINISH is ignored.
    wait_write(16'hFFFF, 8000, found);
    chk("reach_last_write", found, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("done_after_finish", done, 1);
    repeat (5) @(negedge clk);
    chk("idle_after_finish_start", {busy, cpu_hold, done}, 3'b001);
    chk("copy1_remaining", exp_q.size(), 0);
    chk("copy1_checksum", checksum, 8'h00);
    chk("done_rises", done_rises, 1);

    // Copy 2: start from IDLE repeats the copy.
    begin_copy(); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    chk("start_done_drop", {done, cpu_hold, busy}, 3'b011);
    while (!done && n < 7000) begin @(negedge clk); n++; end
    chk("copy2_done_cycle", n, 6146);
    chk("copy2_remaining", exp_q.size(), 0);
    chk("copy2_checksum", checksum, 8'h00);

    // Copy 3: rst pulse during the idx-100 write abandons and restarts.
    begin_copy(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_write(16'hF864, 1000, found);
    chk("reach_idx100", found, 1);
    rst = 1'b1;
    begin_copy();
    #1;
    chk("rst_blocks_write", {ram_we, busy, cpu_hold, checksum}, {1'b0, 1'b1, 1'b1, 8'h00});
    @(negedge clk); rst = 1'b0; n = 0; seen = 1'b0; first_addr = '0; first_data = '0;
    chk("post_rst_state", {ram_we, busy, done, checksum, rom_addr}, {1'b0, 1'b1, 1'b0, 8'h00, 11'd0});
    while (!done && n < 7000) begin
      @(negedge clk); n++;
      if (ram_we && !seen) begin
        seen = 1'b1; first_addr = ram_addr; first_data = ram_wdata;
      end
    end
    chk("rst_restart_first_write", {first_addr, first_data}, {16'hF800, 8'h00});
    chk("copy3_done_cycle", n, 6146);
    chk("copy3_remaining", exp_q.size(), 0);
    chk("copy3_checksum", checksum, 8'h00);

    // Small copier: 16 bytes, RAM address wraps past FFFF.
    begin_copy_s();
    @(negedge clk); rst_s = 1'b0; n = 0;
    while (!done_s && n < 200) begin @(negedge clk); n++; end
    chk("small_done_cycle", n, 50);
    chk("small_checksum", checksum_s, 8'h78);
    chk("small_remaining", exp_s.size(), 0);
    chk("small_writes", n_wr_s, 16);
    chk("small_idle", {busy_s, cpu_hold_s}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
